// File: rtl/wd_pkg.sv
`default_nettype none
// ============================================================================
// Module : wd_pkg -- shared state, fail-code and register-offset definitions
// Rev    : 1.0
// ============================================================================
package wd_pkg;

  typedef enum logic [1:0] {
    ST_DIS    = 2'b00,
    ST_CLOSED = 2'b01,
    ST_OPEN   = 2'b10,
    ST_FAIL   = 2'b11
  } wd_state_e;

  localparam logic [1:0] FL_NONE    = 2'b00;
  localparam logic [1:0] FL_EARLY   = 2'b01;
  localparam logic [1:0] FL_TIMEOUT = 2'b10;
  localparam logic [1:0] FL_BADKEY  = 2'b11;

  localparam logic [1:0] REG_CTRL       = 2'd0;
  localparam logic [1:0] REG_CLOSED_LEN = 2'd1;
  localparam logic [1:0] REG_OPEN_LEN   = 2'd2;
  localparam logic [1:0] REG_SERVICE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/wd_channel.sv
`default_nettype none
// ============================================================================
// Module : wd_channel -- one windowed watchdog: config regs, FSM, counter
// Rev    : 1.0
// ============================================================================
module wd_channel
  import wd_pkg::*;
#(
  parameter int          CW  = 16,
  parameter int          DW  = 16,
  parameter logic [15:0] KEY = 16'hA5C3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr,
  input  logic [1:0]    i_reg,
  input  logic [DW-1:0] i_data,
  output logic          o_fail,
  output logic [1:0]    o_code
);

  wd_state_e     r_state;
  wd_state_e     w_nxt_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] r_closed_len;
  logic [CW-1:0] r_open_len;
  logic [CW-1:0] w_len;
  logic [1:0]    r_code;
  logic [1:0]    w_nxt_code;
  logic          r_lock;
  logic          w_cfg_wr;
  logic          w_ctrl_wr;
  logic          w_srv_wr;
  logic          w_key_ok;
  logic          w_enable;

  assign w_cfg_wr  = i_wr && !r_lock && (r_state != ST_FAIL);
  assign w_ctrl_wr = w_cfg_wr && (i_reg == REG_CTRL);
  assign w_srv_wr  = i_wr && (i_reg == REG_SERVICE);
  assign w_key_ok  = (i_data[15:0] == KEY);
  assign w_enable  = i_data[0];
  // A zero length would make the window degenerate; clamp it to one cycle.
  assign w_len     = (i_data[CW-1:0] == '0) ? CW'(1) : i_data[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock       <= 1'b0;
      r_closed_len <= '1;
      r_open_len   <= '1;
    end else if (w_cfg_wr) begin
      case (i_reg)
        REG_CTRL:       r_lock       <= i_data[1];
        REG_CLOSED_LEN: r_closed_len <= w_len;
        REG_OPEN_LEN:   r_open_len   <= w_len;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_DIS;
      r_cnt   <= '0;
      r_code  <= FL_NONE;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_code  <= w_nxt_code;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_code  = r_code;
    case (r_state)
      ST_DIS: begin
        if (w_ctrl_wr && w_enable) begin
          w_nxt_state = ST_CLOSED;
          w_nxt_cnt   = r_closed_len - CW'(1);
        end
      end
      ST_CLOSED: begin
        if (w_ctrl_wr && !w_enable) begin
          w_nxt_state = ST_DIS;
          w_nxt_cnt   = '0;
        end else if (w_srv_wr) begin
          w_nxt_state = ST_FAIL;
          w_nxt_code  = w_key_ok ? FL_EARLY : FL_BADKEY;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_OPEN;
          w_nxt_cnt   = r_open_len - CW'(1);
        end else begin
          w_nxt_cnt = r_cnt - CW'(1);
        end
      end
      ST_OPEN: begin
        // A good key on the last open cycle still counts as a service.
        if (w_ctrl_wr && !w_enable) begin
          w_nxt_state = ST_DIS;
          w_nxt_cnt   = '0;
        end else if (w_srv_wr && w_key_ok) begin
          w_nxt_state = ST_CLOSED;
          w_nxt_cnt   = r_closed_len - CW'(1);
        end else if (w_srv_wr) begin
          w_nxt_state = ST_FAIL;
          w_nxt_code  = FL_BADKEY;
        end else if (r_cnt == '0) begin
          w_nxt_state = ST_FAIL;
          w_nxt_code  = FL_TIMEOUT;
        end else begin
          w_nxt_cnt = r_cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_fail = (r_state == ST_FAIL);
  assign o_code = r_code;

endmodule
`default_nettype wire

// File: rtl/multi_channel_watchdog.sv
`default_nettype none
// ============================================================================
// Module : multi_channel_watchdog -- NCH windowed watchdogs, address decode
//          and a one-shot system reset pulser
// Rev    : 1.0
// ============================================================================
module multi_channel_watchdog
  import wd_pkg::*;
#(
  parameter int          NCH    = 4,
  parameter int          CW     = 16,
  parameter logic [15:0] KEY    = 16'hA5C3,
  parameter int          RSTLEN = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_wren,
  input  logic [$clog2(NCH)+1:0]           i_abus,
  input  logic [((CW > 16) ? CW : 16)-1:0] i_dbus,
  output logic                             o_rstout,
  output logic [NCH-1:0]                   o_wdfail,
  output logic [2*NCH-1:0]                 o_flstat
);

  localparam int c_aw = $clog2(NCH) + 2;
  localparam int c_dw = (CW > 16) ? CW : 16;

  logic [c_aw-1:0] w_chan;
  logic            r_fired;
  logic            r_rstout;
  logic [15:0]     r_pcnt;

  // Channel indices at or above NCH never match any generated channel.
  assign w_chan = i_abus >> 2;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      wd_channel #(
        .CW  (CW),
        .DW  (c_dw),
        .KEY (KEY)
      ) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_wr   (i_wren && (w_chan == c_aw'(i))),
        .i_reg  (i_abus[1:0]),
        .i_data (i_dbus),
        .o_fail (o_wdfail[i]),
        .o_code (o_flstat[2*i +: 2])
      );
    end
  endgenerate

  // One pulse per reset epoch: r_fired blocks retriggering by later fails.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fired  <= 1'b0;
      r_rstout <= 1'b0;
      r_pcnt   <= '0;
    end else if (!r_fired) begin
      if (|o_wdfail) begin
        r_fired  <= 1'b1;
        r_rstout <= 1'b1;
        r_pcnt   <= 16'(RSTLEN - 1);
      end
    end else if (r_rstout) begin
      if (r_pcnt == '0) begin
        r_rstout <= 1'b0;
      end else begin
        r_pcnt <= r_pcnt - 16'd1;
      end
    end
  end

  assign o_rstout = r_rstout;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_watchdog.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_channel_watchdog -- directed and random stimulus against
//          an elapsed-time reference model of the watchdog windows
// Rev    : 1.0
// ============================================================================
module tb_multi_channel_watchdog;

  localparam int          NCH    = 3;
  localparam int          CW     = 16;
  localparam int          RSTLEN = 64;
  localparam logic [15:0] KEY    = 16'hA5C3;
  localparam int          AW     = 4;
  localparam int          M_DIS  = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_FAIL = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           wren  = 1'b0;
  logic [AW-1:0]  abus  = '0;
  logic [15:0]    dbus  = '0;
  logic           rstout;
  logic [NCH-1:0] wdfail;
  logic [2*NCH-1:0] flstat;

  multi_channel_watchdog #(
    .NCH    (NCH),
    .CW     (CW),
    .KEY    (KEY),
    .RSTLEN (RSTLEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wren   (wren),
    .i_abus   (abus),
    .i_dbus   (dbus),
    .o_rstout (rstout),
    .o_wdfail (wdfail),
    .o_flstat (flstat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  // Model: a running channel is described by the edge its window began;
  // the phase follows from elapsed edges versus the configured lengths.
  int m_st   [NCH];
  int m_start[NCH];
  int m_cl   [NCH];
  int m_ol   [NCH];
  int m_code [NCH];
  bit m_lock [NCH];
  bit m_fired;
  int m_fs;

  function automatic logic [AW-1:0] addr_of(input int ch, input int rg);
    return {ch[1:0], rg[1:0]};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = M_DIS; m_start[c] = 0; m_cl[c] = 65535; m_ol[c] = 65535;
      m_code[c] = 0; m_lock[c] = 1'b0;
    end
    m_fired = 1'b0;
    m_fs    = 0;
  endfunction

  function automatic void m_fail(input int c, input int code);
    m_st[c]   = M_FAIL;
    m_code[c] = code;
    if (!m_fired) begin
      m_fired = 1'b1;
      m_fs    = t;
    end
  endfunction

  function automatic void model_step(input bit wr, input logic [AW-1:0] a, input logic [15:0] d);
    int ch, rg, pre_st;
    bit sel, pre_lock, handled, in_open;
    ch = int'(a >> 2);
    rg = int'(a[1:0]);
    t++;
    for (int c = 0; c < NCH; c++) begin
      sel      = wr && (ch == c);
      pre_lock = m_lock[c];
      pre_st   = m_st[c];
      handled  = 1'b0;
      if (pre_st == M_RUN) begin
        in_open = (t - 1 - m_start[c]) >= m_cl[c];
        if (sel && rg == 0 && !pre_lock && !d[0]) begin
          m_st[c] = M_DIS;
          handled = 1'b1;
        end else if (sel && rg == 3) begin
          handled = 1'b1;
          if (d != KEY)      m_fail(c, 3);
          else if (!in_open) m_fail(c, 1);
          else               m_start[c] = t;
        end
        if (!handled && (t - m_start[c]) >= m_cl[c] + m_ol[c]) m_fail(c, 2);
      end else if (pre_st == M_DIS) begin
        if (sel && rg == 0 && !pre_lock && d[0]) begin
          m_st[c]    = M_RUN;
          m_start[c] = t;
        end
      end
      if (sel && !pre_lock && pre_st != M_FAIL) begin
        case (rg)
          0: m_lock[c] = d[1];
          1: m_cl[c]   = (d == 16'd0) ? 1 : int'(d);
          2: m_ol[c]   = (d == 16'd0) ? 1 : int'(d);
          default: ;
        endcase
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, t);
  endtask

  task automatic compare(input string tag);
    logic [NCH-1:0]   ew;
    logic [2*NCH-1:0] ef;
    logic             er;
    for (int c = 0; c < NCH; c++) begin
      ew[c]        = (m_st[c] == M_FAIL);
      ef[2*c +: 2] = m_code[c][1:0];
    end
    er = m_fired && (t > m_fs) && (t <= m_fs + RSTLEN);
    chk({tag, "/rstout"}, 32'(rstout), 32'(er));
    chk({tag, "/wdfail"}, 32'(wdfail), 32'(ew));
    chk({tag, "/flstat"}, 32'(flstat), 32'(ef));
  endtask

  task automatic tick(input bit wr, input logic [AW-1:0] a, input logic [15:0] d, input string tag);
    @(negedge clk);
    wren = wr; abus = a; dbus = d;
    @(posedge clk);
    model_step(wr, a, d);
    #1 compare(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, tag);
  endtask

  task automatic wr(input int ch, input int rg, input logic [15:0] d, input string tag);
    tick(1'b1, addr_of(ch, rg), d, tag);
  endtask

  // Reset lands mid-cycle so the outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare(tag);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    int          rch, rrg, rr;
    bit          rwr;

    model_reset();
    repeat (2) @(posedge clk);
    #1 compare("reset");
    #1 rst_n = 1'b1;

    // ch0 serviced inside the open window keeps running
    wr(0, 3, KEY, "svc_in_dis");
    wr(0, 1, 16'd4, "ch0_cfg");
    wr(0, 2, 16'd4, "ch0_cfg");
    wr(0, 0, 16'd1, "ch0_en");
    idle(5, "ch0_closed");
    wr(0, 3, KEY, "ch0_svc");
    idle(6, "ch0_run");
    wr(0, 3, KEY, "ch0_svc2");
    wr(0, 0, 16'd0, "ch0_dis");
    idle(12, "ch0_idle");

    // ch1 unserviced: timeout then a single RSTLEN pulse
    wr(1, 1, 16'd4, "ch1_cfg");
    wr(1, 2, 16'd4, "ch1_cfg");
    wr(1, 0, 16'd1, "ch1_en");
    idle(75, "ch1_timeout");

    // early service on ch0, bad key on ch1, then FAIL is absorbing
    async_reset("rst_a");
    wr(0, 1, 16'd4, "early_cfg");
    wr(0, 2, 16'd4, "early_cfg");
    wr(0, 0, 16'd1, "early_en");
    idle(1, "early_wait");
    wr(0, 3, KEY, "early_svc");
    wr(1, 1, 16'd4, "bad_cfg");
    wr(1, 2, 16'd4, "bad_cfg");
    wr(1, 0, 16'd1, "bad_en");
    idle(4, "bad_wait");
    wr(1, 3, 16'h1234, "bad_svc");
    wr(0, 0, 16'd0, "fail_ctrl");
    wr(0, 3, KEY, "fail_svc");
    idle(5, "fail_hold");

    // service on the last open cycle, then a full closed window
    async_reset("rst_b");
    wr(0, 1, 16'd4, "edge_cfg");
    wr(0, 2, 16'd4, "edge_cfg");
    wr(0, 0, 16'd1, "edge_en");
    idle(7, "edge_wait");
    wr(0, 3, KEY, "edge_svc");
    idle(4, "edge_closed");
    wr(0, 3, KEY, "edge_svc2");
    wr(0, 0, 16'd0, "edge_dis");
    wr(2, 1, 16'd0, "zero_len");
    wr(2, 2, 16'd0, "zero_len");
    wr(2, 0, 16'd1, "zero_en");
    idle(1, "zero_wait");
    wr(2, 3, KEY, "zero_svc");
    idle(4, "zero_timeout");

    // LOCK freezes config; ch0 fails too, reset arrives mid-pulse
    async_reset("rst_c");
    wr(3, 0, 16'd1, "bad_chan");
    wr(3, 3, 16'h0000, "bad_chan");
    wr(1, 1, 16'd4, "lock_cfg");
    wr(1, 2, 16'd4, "lock_cfg");
    wr(1, 0, 16'd3, "lock_en");
    wr(1, 0, 16'd0, "lock_dis");
    wr(1, 1, 16'd2, "lock_len");
    idle(8, "lock_timeout");
    wr(0, 0, 16'd1, "lock_ch0");
    wr(0, 3, KEY, "lock_ch0_early");
    idle(4, "pulse");
    async_reset("rst_mid_pulse");
    wr(0, 3, KEY, "post_rst_svc");
    wr(1, 3, KEY, "post_rst_svc");
    idle(3, "post_rst");

    // random traffic; lengths only change on disabled channels
    for (int round = 0; round < 8; round++) begin
      async_reset("rst_rand");
      for (int i = 0; i < 150; i++) begin
        rr  = int'($urandom_range(0, 99));
        rch = int'($urandom_range(0, 3));
        rrg = int'($urandom_range(0, 3));
        rwr = (rr >= 70);
        rd  = '0;
        case (rrg)
          0: rd = {14'd0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0)};
          1, 2: begin
            rd = 16'($urandom_range(0, 6));
            if (rch < NCH && m_st[rch] != M_DIS) rwr = 1'b0;
          end
          default: rd = ($urandom_range(0, 9) == 0) ? 16'($urandom) : KEY;
        endcase
        tick(rwr, addr_of(rch, rrg), rd, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_channel_watchdog.md
MULTI_CHANNEL_WATCHDOG -- requirements
Module: multi_channel_watchdog

Interface
REQ-001 Parameter NCH, default 4: number of independent watchdog channels, 1..8.
REQ-002 Parameter CW, default 16: window counter width, 4..32.
REQ-003 Parameter KEY, default 16'hA5C3: service key pattern.
REQ-004 Parameter RSTLEN, default 64: RSTOUT pulse length in cycles, 1..2^16-1.
REQ-005 CLK  in  1  single clock; all logic is rising-edge clocked.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 WREN  in  1  write strobe, one write per asserted cycle.
REQ-008 ABUS  in  $clog2(NCH)+2  address: upper bits select the channel, low 2 bits select the register.
REQ-009 DBUS  in  max(CW,16)  write data.
REQ-010 RSTOUT  out  1  active-high system reset pulse.
REQ-011 WDFAIL  out  NCH  per-channel sticky fail flag.
REQ-012 FLSTAT  out  2*NCH  per-channel 2-bit fail code; channel i occupies bits [2i+1:2i].

Function
REQ-013 Register map per channel (low ABUS bits): 0 CTRL (bit0 ENABLE, bit1 LOCK); 1 CLOSED_LEN; 2 OPEN_LEN; 3 SERVICE.
REQ-014 CLOSED_LEN and OPEN_LEN writes take DBUS[CW-1:0]; a written value of 0 is stored as 1.
REQ-015 Once LOCK=1, writes to CTRL, CLOSED_LEN and OPEN_LEN of that channel are ignored until RST.
REQ-016 Each channel has four states: DIS, CLOSED, OPEN, FAIL; encoding 00/01/10/11.
REQ-017 DIS->CLOSED occurs in the cycle after a CTRL write with ENABLE=1; the window counter loads CLOSED_LEN-1.
REQ-018 In CLOSED and OPEN the counter decrements once per cycle.
REQ-019 CLOSED->OPEN occurs when the counter is 0; the counter loads OPEN_LEN-1.
REQ-020 OPEN->FAIL occurs when the counter is 0 with no valid service that cycle; the code is 2'b10 (timeout).
REQ-021 A valid service is a SERVICE write with DBUS[15:0]==KEY while in OPEN; the next state is CLOSED and the counter reloads CLOSED_LEN-1.
REQ-022 A SERVICE write in CLOSED -> FAIL with code 2'b01 (early service).
REQ-023 A SERVICE write with a wrong key in CLOSED or OPEN -> FAIL with code 2'b11 (bad key).
REQ-024 A valid service in the same cycle the OPEN counter reaches 0 counts as service; no fail.
REQ-025 A CTRL write with ENABLE=0 in CLOSED or OPEN with LOCK=0 -> DIS; FLSTAT is unchanged.
REQ-026 FAIL is absorbing until RST; WDFAIL[i]=1 and FLSTAT code hold; all channel writes are ignored.
REQ-027 SERVICE writes in DIS are ignored.
REQ-028 Writes to a channel index >= NCH are ignored.
REQ-029 WDFAIL[i] and FLSTAT[i] are registered and assert in the cycle the state becomes FAIL.
REQ-030 Any channel entering FAIL starts the reset pulser.
- RSTOUT rises one cycle after the first WDFAIL bit rises.
- RSTOUT then holds high exactly RSTLEN cycles, then stays low.
- Later channel fails do not retrigger the pulse.

Reset
REQ-031 On RST low, asynchronously:
- all channels go to DIS;
- counters clear; CLOSED_LEN and OPEN_LEN = 2^CW-1; ENABLE and LOCK = 0;
- WDFAIL = 0, FLSTAT = 0, RSTOUT = 0, pulser idle.
REQ-032 Reset asserted mid-pulse terminates RSTOUT immediately.
REQ-033 After RST deasserts, the first register write is accepted on the next rising edge.

Structure
REQ-034 Shared package wd_pkg holds:
- the state enum;
- fail code constants FL_NONE, FL_EARLY, FL_TIMEOUT, FL_BADKEY;
- register offset constants.
REQ-035 Sub-module wd_channel (one per channel, generated NCH times) holds the registers, FSM, counter and fail code. The top holds address decode and the RSTOUT pulser.

Verification
REQ-036 NCH=2, CLOSED_LEN=4, OPEN_LEN=4, enable ch0, KEY written 6 cycles after enable -> ch0 returns to CLOSED; WDFAIL=0; RSTOUT=0.
REQ-037 Enable ch1, no service -> WDFAIL[1]=1 and FLSTAT[3:2]=10 after 8 cycles; RSTOUT high for exactly RSTLEN=64 cycles starting one cycle later.
REQ-038 SERVICE write 2 cycles after enable -> FLSTAT=01 (early service); a SERVICE of 16'h1234 in OPEN -> FLSTAT=11 (bad key).
REQ-039 Valid KEY write in the same cycle the OPEN counter hits 0 -> no fail; the channel stays CLOSED for 4 cycles.
REQ-040 Set LOCK=1, then write ENABLE=0 and CLOSED_LEN=2 -> both ignored; the channel times out with the original lengths.
REQ-041 Pull RST low while RSTOUT=1 and ch0=FAIL -> RSTOUT, WDFAIL and FLSTAT are 0 immediately; all channels are in DIS.
